golomb_vlc_coder: RTL and testbench

Codeword generator for the ProRes AC-level entropy coder. Each cycle it takes one pre-classified value and emits a right-aligned variable-length codeword with its bit length. The value is coded either as a Golomb-Rice code or as an exponential-Golomb code of order k. An optional escape prefix of zeros and an optional trailing sign bit can be added. It sits between the adaptive-codebook selector (upstream) and the bit packer (downstream), with a fixed 2-cycle latency.

---
 rtl/golomb_vlc_coder.sv | 153 +++++++++++++++
 tb/tb_golomb_vlc_coder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/golomb_vlc_coder.sv
// golomb_vlc_coder
//   Codeword generator for the ProRes AC-level entropy coder. Each cycle one
//   pre-classified value is coded as Golomb-Rice (rice_valid) or as an
//   exp-Golomb code of order k (exp_valid). An exp-Golomb code can carry up
//   to three escape zeros, and either code can carry a trailing sign bit.
//   The pipeline has two register stages and a fixed 2-cycle latency. It
//   never stalls.
//
//   Build option: define GOLOMB_AC_SIGN_EN to honor is_ac_level / is_minus.
//   If the macro is not defined, the sign logic is absent and no sign bit is
//   ever appended.
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   input_start/end       frame markers, delayed alongside the data
//   rice_valid            code val as Golomb-Rice (has priority)
//   exp_valid             code val as exp-Golomb
//   val[31:0], k[2:0]     value and code order
//   is_add_setbit[1:0]    escape zeros added to the exp-Golomb length
//   is_ac_level, is_minus append the sign bit / sign value
//   output_valid          sum_n / codeword_length are valid
//   sum_n[31:0]           right-aligned codeword (low 32 bits)
//   codeword_length[31:0] codeword bit count
//   output_start/end      delayed markers
module golomb_vlc_coder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        input_start,
  input  logic        input_end,
  input  logic        rice_valid,
  input  logic        exp_valid,
  input  logic [31:0] val,
  input  logic [2:0]  k,
  input  logic [1:0]  is_add_setbit,
  input  logic        is_ac_level,
  input  logic        is_minus,
  output logic        output_valid,
  output logic [31:0] sum_n,
  output logic [31:0] codeword_length,
  output logic        output_start,
  output logic        output_end
);
  localparam int STAGES = 2;

  // Valid bits and frame markers travel in matching shift registers.
  // Index 0 is the live input.
  logic [STAGES:0] vld_pipe, start_pipe, end_pipe;

  assign vld_pipe[0]   = rice_valid | exp_valid;
  assign start_pipe[0] = input_start;
  assign end_pipe[0]   = input_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe[STAGES:1]   <= '0;
      start_pipe[STAGES:1] <= '0;
      end_pipe[STAGES:1]   <= '0;
    end else begin
      vld_pipe[STAGES:1]   <= vld_pipe[STAGES-1:0];
      start_pipe[STAGES:1] <= start_pipe[STAGES-1:0];
      end_pipe[STAGES:1]   <= end_pipe[STAGES-1:0];
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic [32:0] exp_n;
  logic [5:0]  exp_b;
  logic [7:0]  rice_code;
  logic [7:0]  rice_mask;

  always_comb begin
    exp_n = {1'b0, val} + (33'd1 << k);
    // Priority encoder: the highest set bit wins because it is written last.
    exp_b = '0;
    for (int i = 0; i < 33; i++)
      if (exp_n[i]) exp_b = 6'(i);
    rice_mask = (8'd1 << k) - 8'd1;
    rice_code = (8'd1 << k) | (val[7:0] & rice_mask);
  end

  logic        s1_rice;
  logic [31:0] s1_q;
  logic [5:0]  s1_b;
  logic [32:0] s1_code;
  logic [2:0]  s1_k;
  logic [1:0]  s1_set;
`ifdef GOLOMB_AC_SIGN_EN
  logic        s1_sign;
  logic        s1_minus;
`else
  logic        unused_sign_inputs;
  assign unused_sign_inputs = is_ac_level ^ is_minus;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_rice  <= 1'b0;
      s1_q     <= '0;
      s1_b     <= '0;
      s1_code  <= '0;
      s1_k     <= '0;
      s1_set   <= '0;
`ifdef GOLOMB_AC_SIGN_EN
      s1_sign  <= 1'b0;
      s1_minus <= 1'b0;
`endif
    end else begin
      s1_rice  <= rice_valid;
      s1_q     <= val >> k;
      s1_b     <= exp_b;
      s1_code  <= rice_valid ? {25'd0, rice_code} : exp_n;
      s1_k     <= k;
      s1_set   <= is_add_setbit;
`ifdef GOLOMB_AC_SIGN_EN
      s1_sign  <= is_ac_level;
      s1_minus <= is_minus;
`endif
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [31:0] len_c, sum_c;

  always_comb begin
    // Escape zeros add length only. The code value is not changed by them.
    if (s1_rice)
      len_c = s1_q + 32'd1 + 32'(s1_k);
    else
      len_c = (32'(s1_b) << 1) - 32'(s1_k) + 32'd1 + 32'(s1_set);
    sum_c = s1_code[31:0];
`ifdef GOLOMB_AC_SIGN_EN
    if (s1_sign) begin
      sum_c = {s1_code[30:0], s1_minus};
      len_c = len_c + 32'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_n           <= '0;
      codeword_length <= '0;
    end else begin
      sum_n           <= vld_pipe[1] ? sum_c : '0;
      codeword_length <= vld_pipe[1] ? len_c : '0;
    end
  end

  assign output_valid = vld_pipe[STAGES];
  assign output_start = start_pipe[STAGES];
  assign output_end   = end_pipe[STAGES];

endmodule

// File: tb/tb_golomb_vlc_coder.sv
// Directed bench for golomb_vlc_coder. Vectors stream back to back. Each
// result is checked on the falling edge two cycles after its vector is
// driven. The expected sum and length come from hand-computed table entries,
// with one pair for each build of the sign option.
module tb_golomb_vlc_coder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        input_start, input_end, rice_valid, exp_valid;
  logic [31:0] val;
  logic [2:0]  k;
  logic [1:0]  is_add_setbit;
  logic        is_ac_level, is_minus;
  logic        output_valid, output_start, output_end;
  logic [31:0] sum_n, codeword_length;

  golomb_vlc_coder dut (
    .clk(clk), .reset_n(reset_n),
    .input_start(input_start), .input_end(input_end),
    .rice_valid(rice_valid), .exp_valid(exp_valid),
    .val(val), .k(k), .is_add_setbit(is_add_setbit),
    .is_ac_level(is_ac_level), .is_minus(is_minus),
    .output_valid(output_valid), .sum_n(sum_n),
    .codeword_length(codeword_length),
    .output_start(output_start), .output_end(output_end)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        rv, ev;
    logic [31:0] v;
    logic [2:0]  kk;
    logic [1:0]  st;
    logic        ac, mi, s, e;
    logic [31:0] ss, sl;   // expected sum/len, sign option on
    logic [31:0] ns, nl;   // expected sum/len, sign option off
  } vec_t;

  function automatic vec_t mk(logic rv, logic ev, logic [31:0] v, logic [2:0] kk,
                              logic [1:0] st, logic ac, logic mi, logic s, logic e,
                              logic [31:0] ss, logic [31:0] sl,
                              logic [31:0] ns, logic [31:0] nl);
    vec_t r;
    r.rv = rv; r.ev = ev; r.v = v; r.kk = kk; r.st = st; r.ac = ac; r.mi = mi;
    r.s = s; r.e = e; r.ss = ss; r.sl = sl; r.ns = ns; r.nl = nl;
    return r;
  endfunction

  task automatic drive(input vec_t x);
    rice_valid = x.rv; exp_valid = x.ev; val = x.v; k = x.kk;
    is_add_setbit = x.st; is_ac_level = x.ac; is_minus = x.mi;
    input_start = x.s; input_end = x.e;
  endtask

  task automatic idle();
    rice_valid = 0; exp_valid = 0; val = '0; k = '0; is_add_setbit = '0;
    is_ac_level = 0; is_minus = 0; input_start = 0; input_end = 0;
  endtask

  task automatic check_vec(input int i, input vec_t x);
    logic [31:0] es, el;
    string t;
`ifdef GOLOMB_AC_SIGN_EN
    es = x.ss; el = x.sl;
`else
    es = x.ns; el = x.nl;
`endif
    t = $sformatf("v%0d", i);
    chk({t, ".valid"}, 64'(output_valid), 64'(x.rv | x.ev));
    chk({t, ".sum"},   64'(sum_n), 64'(es));
    chk({t, ".len"},   64'(codeword_length), 64'(el));
    chk({t, ".start"}, 64'(output_start), 64'(x.s));
    chk({t, ".end"},   64'(output_end), 64'(x.e));
  endtask

  vec_t vecs[$];

  initial begin
    //            rv ev val           k  st ac mi s  e   ss   sl         ns   nl
    vecs.push_back(mk(1, 0, 32'd1,     0, 0, 0, 0, 1, 1,   1,   2,         1,   2));
    vecs.push_back(mk(0, 0, 32'd0,     0, 0, 0, 0, 1, 0,   0,   0,         0,   0));
    vecs.push_back(mk(1, 0, 32'd2,     0, 0, 1, 1, 0, 0,   3,   4,         1,   3));
    vecs.push_back(mk(0, 1, 32'd0,     2, 3, 1, 0, 0, 0,   8,   7,         4,   6));
    vecs.push_back(mk(0, 1, 32'd5,     0, 0, 0, 0, 0, 0,   6,   5,         6,   5));
    vecs.push_back(mk(1, 0, 32'd21,    3, 0, 0, 0, 0, 0,  13,   6,        13,   6));
    vecs.push_back(mk(0, 1, 32'd100,   7, 1, 1, 1, 0, 1, 457,  10,       228,   9));
    vecs.push_back(mk(1, 1, 32'd7,     1, 2, 0, 0, 1, 0,   3,   5,         3,   5));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFF, 0, 0, 1, 1, 0, 0, 1, 66,        0,  65));
    vecs.push_back(mk(1, 0, 32'h8000_0000, 7, 0, 0, 0, 0, 0, 128, 16777224, 128, 16777224));
    vecs.push_back(mk(0, 1, 32'd0,     7, 0, 0, 0, 0, 0, 128,   8,       128,   8));
    vecs.push_back(mk(0, 0, 32'd0,     0, 0, 0, 0, 0, 1,   0,   0,         0,   0));

    idle();
    reset_n = 0;
    repeat (2) @(negedge clk);
    chk("rst.valid", 64'(output_valid), 64'd0);
    chk("rst.sum",   64'(sum_n), 64'd0);
    chk("rst.len",   64'(codeword_length), 64'd0);
    chk("rst.start", 64'(output_start), 64'd0);
    reset_n = 1;

    // Streaming: the vector driven on falling edge j is checked on falling edge j+2.
    for (int j = 0; j < vecs.size() + 2; j++) begin
      @(negedge clk);
      if (j >= 2) check_vec(j - 2, vecs[j - 2]);
      if (j < vecs.size()) drive(vecs[j]); else idle();
    end

    // A mid-stream reset discards the codewords that are in flight.
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    chk("pre_rst.valid", 64'(output_valid), 64'd1);
    #2 reset_n = 0;
    #1;
    chk("async_rst.valid", 64'(output_valid), 64'd0);
    chk("async_rst.sum",   64'(sum_n), 64'd0);
    chk("async_rst.len",   64'(codeword_length), 64'd0);
    chk("async_rst.start", 64'(output_start), 64'd0);
    idle();
    repeat (2) @(negedge clk);
    reset_n = 1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d.valid", j), 64'(output_valid), 64'd0);
    end

    // The first valid after reset appears two cycles later.
    drive(vecs[4]);
    @(negedge clk);
    idle();
    chk("first.early", 64'(output_valid), 64'd0);
    @(negedge clk);
    chk("first.valid", 64'(output_valid), 64'd1);
    chk("first.sum",   64'(sum_n), 64'd6);
    chk("first.len",   64'(codeword_length), 64'd5);
    @(negedge clk);
    chk("first.after", 64'(output_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
